// File: rtl/dcm_phase_ctrl_pkg.sv
// Shared types for the DCM phase controller: FSM state enum and counter sizing helper.
package dcm_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RST,
    ST_WAIT_LOCK,
    ST_IDLE,
    ST_PS_STEP,
    ST_PS_WAIT
  } state_t;

  // Bits needed for a counter that runs 0 .. n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dcm_phase_ctrl_if.sv
// DCM-facing signal bundle: reset, phase-shift handshake and lock status.
// master = controller side, slave = DCM side.
interface dcm_phase_ctrl_if;
  logic DCM_RST;
  logic DCM_PSEN;
  logic DCM_PSINCDEC;
  logic DCM_LOCKED;
  logic DCM_PSDONE;

  modport master (output DCM_RST, DCM_PSEN, DCM_PSINCDEC,
                  input  DCM_LOCKED, DCM_PSDONE);
  modport slave  (input  DCM_RST, DCM_PSEN, DCM_PSINCDEC,
                  output DCM_LOCKED, DCM_PSDONE);
endinterface

// File: rtl/dcm_phase_ctrl_lock_filter.sv
// dcm_lock_filter: synchronises the asynchronous LOCKED, qualifies it over
// LOCK_FILTER consecutive high cycles while enabled, and flags loss of lock
// after two consecutive synchronised-low cycles.
module dcm_lock_filter
  import dcm_phase_ctrl_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = 16
) (
  input  logic CLK,
  input  logic resetb,
  input  logic locked,
  input  logic en,
  output logic qualified,
  output logic lost
);

  localparam int unsigned CW = cnt_width(LOCK_FILTER);
  localparam logic [CW-1:0] LAST = CW'(LOCK_FILTER - 1);

  logic [1:0]    sync;
  logic          lk_s;
  logic          prev_low;
  logic [CW-1:0] cnt;

  assign lk_s = sync[1];

  // Two-flop synchroniser for LOCKED.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb) sync <= '0;
    else         sync <= {sync[0], locked};
  end

  // Remember whether the previous synchronised sample was low.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb) prev_low <= 1'b0;
    else         prev_low <= ~lk_s;
  end

  // Consecutive-high counter, saturates one below the filter length.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb)              cnt <= '0;
    else if (!en || !lk_s)    cnt <= '0;
    else if (cnt != LAST)     cnt <= cnt + CW'(1);
  end

  assign qualified = en & lk_s & (cnt == LAST);
  assign lost      = ~lk_s & prev_low;

endmodule

// File: rtl/dcm_phase_ctrl.sv
// dcm_phase_ctrl: DCM reset/lock sequencer and one-tap-at-a-time dynamic
// phase-shift stepper toward a clamped signed target.
// Optional PSDONE timeout enabled by defining DCM_CTRL_TIMEOUT_EN.
module dcm_phase_ctrl
  import dcm_phase_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 8,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned PS_WIDTH       = 8,
  parameter int unsigned PS_MAX         = 127,
  parameter int unsigned PSDONE_TIMEOUT = 1024
) (
  input  logic                       CLK,
  input  logic                       resetb,
  input  logic                       START,
  input  logic                       PS_REQ,
  input  logic signed [PS_WIDTH-1:0] PS_TARGET,
  dcm_phase_ctrl_if.master           dcm,
  output logic                       READY,
  output logic                       PS_BUSY,
  output logic signed [PS_WIDTH-1:0] PS_CURRENT,
  output logic                       LOCK_LOST,
  output logic                       ERROR
);

  localparam int unsigned RW = cnt_width(RST_CYCLES);
  localparam logic signed [PS_WIDTH-1:0] PMAX = PS_WIDTH'(PS_MAX);
  localparam logic signed [PS_WIDTH-1:0] NMAX = -PMAX;

  state_t                       state, state_n;
  logic [RW-1:0]                rst_cnt;
  logic signed [PS_WIDTH-1:0]   target_q, target_clamped, cur_q;
  logic                         dir_q;
  logic                         lock_lost_q, error_q;
  logic                         qualified, lost, timeout, in_run;

  assign in_run     = (state == ST_IDLE) || (state == ST_PS_STEP) || (state == ST_PS_WAIT);
  assign PS_CURRENT = cur_q;
  assign LOCK_LOST  = lock_lost_q;
  assign ERROR      = error_q;

  dcm_lock_filter #(.LOCK_FILTER(LOCK_FILTER)) u_lock_filter (
    .CLK       (CLK),
    .resetb    (resetb),
    .locked    (dcm.DCM_LOCKED),
    .en        (state == ST_WAIT_LOCK),
    .qualified (qualified),
    .lost      (lost)
  );

`ifdef DCM_CTRL_TIMEOUT_EN
  localparam int unsigned TW = cnt_width(PSDONE_TIMEOUT);
  logic [TW-1:0] to_cnt;

  // Count cycles spent in PS_WAIT.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb)                  to_cnt <= '0;
    else if (state == ST_PS_WAIT) to_cnt <= to_cnt + TW'(1);
    else                          to_cnt <= '0;
  end

  assign timeout = (state == ST_PS_WAIT) && !dcm.DCM_PSDONE &&
                   (to_cnt == TW'(PSDONE_TIMEOUT - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (PSDONE_TIMEOUT != 0);
  assign timeout            = 1'b0;
`endif

  // Clamp the requested target into [-PS_MAX, +PS_MAX].
  always_comb begin
    target_clamped = PS_TARGET;
    if (PS_TARGET > PMAX)      target_clamped = PMAX;
    else if (PS_TARGET < NMAX) target_clamped = NMAX;
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb) state <= ST_RST;
    else         state <= state_n;
  end

  // Next state and DCM/status outputs.
  always_comb begin
    state_n          = state;
    dcm.DCM_RST      = 1'b0;
    dcm.DCM_PSEN     = 1'b0;
    dcm.DCM_PSINCDEC = 1'b0;
    READY            = in_run;
    PS_BUSY          = (state == ST_PS_STEP) || (state == ST_PS_WAIT) ||
                       (in_run && (cur_q != target_q));
    unique case (state)
      ST_RST: begin
        dcm.DCM_RST = 1'b1;
        if (rst_cnt == RW'(RST_CYCLES - 1)) state_n = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: if (qualified) state_n = ST_IDLE;
      ST_IDLE: begin
        if (lost)                    state_n = ST_RST;
        else if (cur_q != target_q)  state_n = ST_PS_STEP;
      end
      ST_PS_STEP: begin
        dcm.DCM_PSEN     = 1'b1;
        dcm.DCM_PSINCDEC = dir_q;
        state_n          = lost ? ST_RST : ST_PS_WAIT;
      end
      ST_PS_WAIT: begin
        if (lost || timeout)      state_n = ST_RST;
        else if (dcm.DCM_PSDONE)  state_n = ST_IDLE;
      end
      default: state_n = ST_RST;
    endcase
    if (START) state_n = ST_RST;
  end

  // Reset-sequence length counter; START restarts it.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb)                      rst_cnt <= '0;
    else if (state == ST_RST && !START) rst_cnt <= rst_cnt + RW'(1);
    else                              rst_cnt <= '0;
  end

  // Target register; survives START and loss of lock.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb)     target_q <= '0;
    else if (PS_REQ) target_q <= target_clamped;
  end

  // Direction is fixed in IDLE so a PS_REQ racing the step cannot push PS_CURRENT past the limit.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb)               dir_q <= 1'b0;
    else if (state == ST_IDLE) dir_q <= (target_q > cur_q);
  end

  // Applied phase taps: cleared by DCM reset, moved one tap per PSDONE.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb)                                    cur_q <= '0;
    else if (state == ST_RST)                       cur_q <= '0;
    else if (state == ST_PS_WAIT && dcm.DCM_PSDONE) cur_q <= dir_q ? cur_q + PS_WIDTH'(1)
                                                                   : cur_q - PS_WIDTH'(1);
  end

  // Sticky status flags, cleared only by START.
  always_ff @(posedge CLK or negedge resetb) begin
    if (!resetb) begin
      lock_lost_q <= 1'b0;
      error_q     <= 1'b0;
    end else if (START) begin
      lock_lost_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      if (lost && in_run) lock_lost_q <= 1'b1;
      if (timeout)        error_q     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dcm_phase_ctrl.sv
// Self-checking bench for dcm_phase_ctrl with a behavioural DCM
// (PSDONE 3 cycles after PSEN, LOCKED 20 cycles after DCM_RST release).
module tb_dcm_phase_ctrl;

  logic              CLK = 1'b0;
  logic              resetb = 1'b0;
  logic              START = 1'b0;
  logic              PS_REQ = 1'b0;
  logic signed [7:0] PS_TARGET = '0;
  logic              READY, PS_BUSY, LOCK_LOST, ERROR;
  logic signed [7:0] PS_CURRENT;

  dcm_phase_ctrl_if dif();

  dcm_phase_ctrl #(
    .RST_CYCLES(8), .LOCK_FILTER(16), .PS_WIDTH(8), .PS_MAX(127), .PSDONE_TIMEOUT(1024)
  ) dut (
    .CLK(CLK), .resetb(resetb), .START(START), .PS_REQ(PS_REQ), .PS_TARGET(PS_TARGET),
    .dcm(dif), .READY(READY), .PS_BUSY(PS_BUSY), .PS_CURRENT(PS_CURRENT),
    .LOCK_LOST(LOCK_LOST), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  // DCM model
  logic       drop_lock = 1'b0;
  logic       suppress_done = 1'b0;
  logic       locked_q = 1'b0;
  int         lock_cnt = 0;
  logic [1:0] ps_pipe = '0;
  logic       psdone_q = 1'b0;

  always @(posedge CLK) begin
    if (dif.DCM_RST) begin
      lock_cnt <= 0;
      locked_q <= 1'b0;
    end else begin
      if (lock_cnt < 20) lock_cnt <= lock_cnt + 1;
      if (lock_cnt == 19) locked_q <= 1'b1;
    end
    ps_pipe  <= {ps_pipe[0], dif.DCM_PSEN};
    psdone_q <= ps_pipe[1] & ~suppress_done;
  end

  assign dif.DCM_LOCKED = locked_q & ~drop_lock;
  assign dif.DCM_PSDONE = psdone_q;

  // Reference model: taps applied = acknowledged inc steps minus acknowledged dec steps since DCM reset.
  int n_inc = 0, n_dec = 0, model_cur = 0;
  int viol_proto = 0, viol_cur = 0, viol_range = 0;
  bit outstanding = 1'b0, mdir = 1'b0;

  always @(negedge CLK) begin
    if (!resetb || dif.DCM_RST) begin
      model_cur   <= 0;
      outstanding <= 1'b0;
    end else begin
      if (int'(PS_CURRENT) != model_cur) viol_cur <= viol_cur + 1;
      if (dif.DCM_PSEN) begin
        if (outstanding) viol_proto <= viol_proto + 1;
        outstanding <= 1'b1;
        mdir        <= dif.DCM_PSINCDEC;
        if (dif.DCM_PSINCDEC) n_inc <= n_inc + 1;
        else                  n_dec <= n_dec + 1;
      end else if (dif.DCM_PSDONE && outstanding) begin
        outstanding <= 1'b0;
        model_cur   <= model_cur + (mdir ? 1 : -1);
      end
    end
    if (int'(PS_CURRENT) > 127 || int'(PS_CURRENT) < -127) viol_range <= viol_range + 1;
  end

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_req(input int t);
    PS_TARGET = 8'(t);
    PS_REQ    = 1'b1;
    tick();
    PS_REQ    = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int k = 0;
    while (!READY && k < bound) begin
      tick();
      k++;
    end
    check({name, "_ready"}, int'(READY), 1);
  endtask

  task automatic wait_quiet(input string name, input int bound);
    int k = 0;
    tick();
    tick();
    while (PS_BUSY && k < bound) begin
      tick();
      k++;
    end
    check({name, "_idle"}, int'(PS_BUSY), 0);
  endtask

  function automatic int clampi(input int t);
    return (t > 127) ? 127 : ((t < -127) ? -127 : t);
  endfunction

  typedef struct {
    int target;
    int exp_cur;
    int exp_inc;
    int exp_dec;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, k, lock_at, inc0, dec0, t1, last;

    vecs[0] = '{5, 5, 5, 0};
    vecs[1] = '{0, 0, 0, 5};
    vecs[2] = '{-128, -127, 0, 127};
    vecs[3] = '{127, 127, 254, 0};
    vecs[4] = '{-3, -3, 0, 130};
    vecs[5] = '{-3, -3, 0, 0};

    // Reset state
    repeat (3) tick();
    check("rst_dcm_rst", int'(dif.DCM_RST), 1);
    check("rst_outputs", int'({READY, dif.DCM_PSEN, dif.DCM_PSINCDEC, PS_BUSY, LOCK_LOST, ERROR}), 0);
    check("rst_current", int'(PS_CURRENT), 0);

    @(posedge CLK);
    #1 resetb = 1'b1;
    n = 0;
    while (dif.DCM_RST && n < 50) begin
      n++;
      tick();
    end
    check("rst_cycles", n, 8);

    k = 0;
    lock_at = -1;
    while (!READY && k < 200) begin
      if (dif.DCM_LOCKED && lock_at < 0) lock_at = k;
      tick();
      k++;
    end
    check("ready_latency", k - lock_at, 18);
    check("ready_busy", int'(PS_BUSY), 0);

    // Table-driven walks
    foreach (vecs[i]) begin
      inc0 = n_inc;
      dec0 = n_dec;
      pulse_req(vecs[i].target);
      wait_quiet($sformatf("vec%0d", i), 3000);
      check($sformatf("vec%0d_cur", i), int'(PS_CURRENT), vecs[i].exp_cur);
      check($sformatf("vec%0d_inc", i), n_inc - inc0, vecs[i].exp_inc);
      check($sformatf("vec%0d_dec", i), n_dec - dec0, vecs[i].exp_dec);
    end

    // Redirect mid-walk: +5 interrupted at +3 by -2
    pulse_req(0);
    wait_quiet("redir_home", 500);
    inc0 = n_inc;
    dec0 = n_dec;
    pulse_req(5);
    k = 0;
    while (!(dif.DCM_PSEN && PS_CURRENT == 3) && k < 200) begin
      tick();
      k++;
    end
    check("redir_seen", int'(dif.DCM_PSEN && PS_CURRENT == 3), 1);
    pulse_req(-2);
    wait_quiet("redir", 500);
    check("redir_cur", int'(PS_CURRENT), -2);
    check("redir_inc", n_inc - inc0, 4);
    check("redir_dec", n_dec - dec0, 6);

    // One-cycle LOCKED glitch is ignored
    drop_lock = 1'b1;
    tick();
    drop_lock = 1'b0;
    repeat (8) tick();
    check("glitch_lost", int'(LOCK_LOST), 0);
    check("glitch_ready", int'(READY), 1);

    // Three-cycle drop: loss of lock, reset, relock, re-walk
    drop_lock = 1'b1;
    repeat (3) tick();
    drop_lock = 1'b0;
    k = 0;
    while (!dif.DCM_RST && k < 10) begin
      tick();
      k++;
    end
    check("loss_dcm_rst", int'(dif.DCM_RST), 1);
    check("loss_flag", int'(LOCK_LOST), 1);
    check("loss_ready", int'(READY), 0);
    tick();
    check("loss_cur_zero", int'(PS_CURRENT), 0);
    dec0 = n_dec;
    wait_ready("relock", 300);
    wait_quiet("relock", 500);
    check("relock_cur", int'(PS_CURRENT), -2);
    check("relock_dec", n_dec - dec0, 2);
    check("relock_sticky", int'(LOCK_LOST), 1);

    // START clears LOCK_LOST and restarts
    pulse_start();
    check("start_clear", int'(LOCK_LOST), 0);
    check("start_rst", int'(dif.DCM_RST), 1);
    wait_ready("start", 300);
    wait_quiet("start", 500);
    check("start_cur", int'(PS_CURRENT), -2);

    // PSDONE suppressed
    suppress_done = 1'b1;
    pulse_req(-1);
    k = 0;
    while (!dif.DCM_PSEN && k < 50) begin
      tick();
      k++;
    end
    check("stall_psen", int'(dif.DCM_PSEN), 1);
`ifdef DCM_CTRL_TIMEOUT_EN
    k = 0;
    while (!ERROR && k < 1100) begin
      tick();
      k++;
    end
    check("timeout_cycles", k, 1025);
    check("timeout_error", int'(ERROR), 1);
    check("timeout_rst", int'(dif.DCM_RST), 1);
    suppress_done = 1'b0;
    pulse_start();
    check("timeout_clear", int'(ERROR), 0);
`else
    repeat (1100) tick();
    check("stall_error", int'(ERROR), 0);
    check("stall_busy", int'(PS_BUSY), 1);
    check("stall_cur", int'(PS_CURRENT), -2);
    suppress_done = 1'b0;
    pulse_start();
    check("stall_rst", int'(dif.DCM_RST), 1);
`endif
    wait_ready("recover", 300);
    wait_quiet("recover", 500);
    check("recover_cur", int'(PS_CURRENT), -1);

    // Randomized targets, sometimes retargeted mid-walk
    for (int i = 0; i < 12; i++) begin
      t1 = int'($urandom_range(255)) - 128;
      pulse_req(t1);
      last = t1;
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(40)) tick();
        t1 = int'($urandom_range(255)) - 128;
        pulse_req(t1);
        last = t1;
      end
      wait_quiet($sformatf("rand%0d", i), 3000);
      check($sformatf("rand%0d_cur", i), int'(PS_CURRENT), clampi(last));
    end

    check("protocol_overlap", viol_proto, 0);
    check("model_tracking", viol_cur, 0);
    check("range_limit", viol_range, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
